// File: rtl/control_sequencer.sv
// -----------------------------------------------------------------------------
// control_sequencer
//   Hard-wired Moore control unit for a simple bus-based datapath. Every
//   instruction runs a common fetch (T0-T2), a decode step (T3) and, for
//   ALU-class opcodes, an execute/write-back tail (T4-T5, plus T6 for mul/div).
//   The halt opcode parks the sequencer in HALT until Clear.
//
// Ports
//   Clock            in   rising-edge clock for all state
//   Clear            in   asynchronous active-low reset
//   IR[31:0]         in   datapath instruction register; opcode = IR[31:27]
//   PC_Out, MDR_Out,
//   ZLO_Out, ZHI_Out out  bus-source selects
//   PC_In, MAR_In, MDR_In, IR_In, Y_In,
//   ZLO_In, ZHI_In, LO_In, HI_In
//                    out  register load enables
//   IncPC, Read      out  PC increment / memory read strobes
//   Gra, Grb, Grc,
//   R_In, R_Out      out  register-field select-and-encode controls
//   CONTROL[4:0]     out  ALU operation select (non-zero only in T4)
//   Run              out  high unless halted
//   Illegal          out  one-cycle pulse in T3 for an undefined opcode
// -----------------------------------------------------------------------------
module control_sequencer (
  input  logic        Clock,
  input  logic        Clear,
  input  logic [31:0] IR,
  output logic        PC_Out,
  output logic        MDR_Out,
  output logic        ZLO_Out,
  output logic        ZHI_Out,
  output logic        PC_In,
  output logic        MAR_In,
  output logic        MDR_In,
  output logic        IR_In,
  output logic        Y_In,
  output logic        ZLO_In,
  output logic        ZHI_In,
  output logic        LO_In,
  output logic        HI_In,
  output logic        IncPC,
  output logic        Read,
  output logic        Gra,
  output logic        Grb,
  output logic        Grc,
  output logic        R_In,
  output logic        R_Out,
  output logic [4:0]  CONTROL,
  output logic        Run,
  output logic        Illegal
);

  typedef enum logic [3:0] {
    S_RST  = 4'd0,
    S_T0   = 4'd1,
    S_T1   = 4'd2,
    S_T2   = 4'd3,
    S_T3   = 4'd4,
    S_T4   = 4'd5,
    S_T5   = 4'd6,
    S_T6   = 4'd7,
    S_HALT = 4'd8
  } state_t;

  localparam logic [4:0] OP_MUL  = 5'b01111;
  localparam logic [4:0] OP_DIV  = 5'b10000;
  localparam logic [4:0] OP_HALT = 5'b11011;

  state_t     r_state;
  state_t     w_next;
  logic [4:0] r_opcode;
  logic [4:0] w_ir_op;
  logic       w_unused_ir;

  // IR is itself a register in the datapath, so reading it live in T3 does
  // not create a glitch path; earlier states never look at it.
  assign w_ir_op     = IR[31:27];
  assign w_unused_ir = ^IR[26:0];

  function automatic logic is_muldiv(input logic [4:0] op);
    return (op == OP_MUL) || (op == OP_DIV);
  endfunction

  function automatic logic is_alu(input logic [4:0] op);
    return ((op >= 5'b00001) && (op <= 5'b01001)) || is_muldiv(op);
  endfunction

  // State and sampled-opcode registers
  always_ff @(posedge Clock or negedge Clear) begin
    if (!Clear) begin
      r_state  <= S_RST;
      r_opcode <= 5'b00000;
    end else begin
      r_state <= w_next;
      // Captured once at the end of T3 so T4-T6 ignore later IR changes.
      if (r_state == S_T3)
        r_opcode <= w_ir_op;
    end
  end

  // Next-state and Moore output decode
  always_comb begin
    w_next  = r_state;
    PC_Out  = 1'b0;
    MDR_Out = 1'b0;
    ZLO_Out = 1'b0;
    ZHI_Out = 1'b0;
    PC_In   = 1'b0;
    MAR_In  = 1'b0;
    MDR_In  = 1'b0;
    IR_In   = 1'b0;
    Y_In    = 1'b0;
    ZLO_In  = 1'b0;
    ZHI_In  = 1'b0;
    LO_In   = 1'b0;
    HI_In   = 1'b0;
    IncPC   = 1'b0;
    Read    = 1'b0;
    Gra     = 1'b0;
    Grb     = 1'b0;
    Grc     = 1'b0;
    R_In    = 1'b0;
    R_Out   = 1'b0;
    CONTROL = 5'b00000;
    Run     = 1'b1;
    Illegal = 1'b0;

    case (r_state)
      S_RST: begin
        w_next = S_T0;
      end
      S_T0: begin
        PC_Out = 1'b1;
        MAR_In = 1'b1;
        IncPC  = 1'b1;
        ZLO_In = 1'b1;
        w_next = S_T1;
      end
      S_T1: begin
        ZLO_Out = 1'b1;
        PC_In   = 1'b1;
        Read    = 1'b1;
        MDR_In  = 1'b1;
        w_next  = S_T2;
      end
      S_T2: begin
        MDR_Out = 1'b1;
        IR_In   = 1'b1;
        w_next  = S_T3;
      end
      S_T3: begin
        if (is_alu(w_ir_op)) begin
          Grb    = 1'b1;
          R_Out  = 1'b1;
          Y_In   = 1'b1;
          w_next = S_T4;
        end else if (w_ir_op == OP_HALT) begin
          w_next = S_HALT;
        end else begin
          Illegal = 1'b1;
          w_next  = S_T0;
        end
      end
      S_T4: begin
        Grc     = 1'b1;
        R_Out   = 1'b1;
        ZLO_In  = 1'b1;
        ZHI_In  = is_muldiv(r_opcode);
        // ALU select codes are the opcode shifted down by one.
        CONTROL = r_opcode - 5'd1;
        w_next  = S_T5;
      end
      S_T5: begin
        ZLO_Out = 1'b1;
        if (is_muldiv(r_opcode)) begin
          LO_In  = 1'b1;
          w_next = S_T6;
        end else begin
          Gra    = 1'b1;
          R_In   = 1'b1;
          w_next = S_T0;
        end
      end
      S_T6: begin
        ZHI_Out = 1'b1;
        HI_In   = 1'b1;
        w_next  = S_T0;
      end
      S_HALT: begin
        Run    = 1'b0;
        w_next = S_HALT;
      end
      default: begin
        w_next = S_RST;
      end
    endcase
  end

endmodule
